// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer that wraps one parallel N-point FFT.
// It collects N serial samples into a frame, holds the frame on fft_data_in
// while the FFT pipeline settles, captures fft_data_out, then streams the
// result out serially with a last flag.
// Optional build macro: FFT_CTRL_BITREV_EN -- when defined, results are read
// out in bit-reversed index order (natural frequency order for the FFT).
`timescale 1ns/1ps

module fft_frame_ctrl #(
    parameter int N            = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FFT_LATENCY  = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SAMPLE_WIDTH-1:0]   s_data,
    output logic [N*SAMPLE_WIDTH-1:0] fft_data_in,
    input  logic [N*SAMPLE_WIDTH-1:0] fft_data_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [SAMPLE_WIDTH-1:0]   m_data,
    output logic                      m_last,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      frame_count
);

    localparam int IDX_W  = $clog2(N);
    localparam int WAIT_W = (FFT_LATENCY < 2) ? 1 : $clog2(FFT_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        wr_idx;
    logic [IDX_W-1:0]        rd_idx;
    logic [IDX_W-1:0]        rd_sel;
    logic [WAIT_W-1:0]       wait_cnt;
    logic [SAMPLE_WIDTH-1:0] in_buf  [N];
    logic [SAMPLE_WIDTH-1:0] out_buf [N];

    logic s_hs;
    logic m_hs;
    logic in_last;
    logic out_last;
    logic wait_done;

    assign s_hs      = s_valid & s_ready;
    assign m_hs      = m_valid & m_ready;
    assign in_last   = (wr_idx == IDX_W'(N - 1));
    assign out_last  = (rd_idx == IDX_W'(N - 1));
    assign wait_done = (wait_cnt == WAIT_W'(FFT_LATENCY));

    // The FFT sees the input buffer directly, so its input is registered and
    // stays frozen outside COLLECT.
    for (genvar i = 0; i < N; i++) begin : g_pack
        assign fft_data_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = in_buf[i];
    end

`ifdef FFT_CTRL_BITREV_EN
    // Reverse the read index bits so results leave in natural frequency order.
    always_comb begin
        rd_sel = '0;
        for (int b = 0; b < IDX_W; b++) begin
            rd_sel[b] = rd_idx[IDX_W-1-b];
        end
    end
`else
    assign rd_sel = rd_idx;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with non-blocking
        // assignments so every register samples pre-edge values.
        if (rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: collect N samples, wait out the FFT, drain N results.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_COLLECT: if (s_hs && !flush && in_last) state_nxt = ST_WAIT;
            ST_WAIT:    if (wait_done)                 state_nxt = ST_DRAIN;
            ST_DRAIN:   if (m_hs && out_last)          state_nxt = ST_COLLECT;
            default:                                   state_nxt = ST_COLLECT;
        endcase
    end

    // Output decode from the current state and read index.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        if (state == ST_COLLECT) begin
            s_ready = 1'b1;
        end
        if (state == ST_DRAIN) begin
            m_valid = 1'b1;
            m_last  = out_last;
            m_data  = out_buf[rd_sel];
        end
        busy = (state != ST_COLLECT) || (wr_idx != '0);
    end

    // Datapath: indices, latency counter, frame buffers and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx      <= '0;
            rd_idx      <= '0;
            wait_cnt    <= '0;
            frame_count <= '0;
            // NOTE: both buffers are reset because fft_data_in and m_data must
            // read zero after reset; this forces a resettable flop per bit.
            for (int i = 0; i < N; i++) begin
                in_buf[i]  <= '0;
                out_buf[i] <= '0;
            end
        end else begin
            case (state)
                ST_COLLECT: begin
                    // flush wins over a simultaneous handshake: sample dropped.
                    if (flush) begin
                        wr_idx <= '0;
                    end else if (s_hs) begin
                        in_buf[wr_idx] <= s_data;
                        if (in_last) begin
                            wr_idx   <= '0;
                            wait_cnt <= '0;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        for (int i = 0; i < N; i++) begin
                            out_buf[i] <= fft_data_out[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                        end
                        rd_idx <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (m_hs) begin
                        if (out_last) begin
                            rd_idx      <= '0;
                            frame_count <= frame_count + 1'b1;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    wr_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Testbench for fft_frame_ctrl. Three instances (FFT_LATENCY 0, 1 and 3) share
// one stimulus stream; each has its own FFT stub (input delayed by the latency,
// every element +16'h0100) and its own transaction-level reference model.
// Honors FFT_CTRL_BITREV_EN for the expected read order.
`timescale 1ns/1ps

module tb_fft_frame_ctrl;

    localparam int N  = 4;
    localparam int SW = 16;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          s_valid;
    logic [SW-1:0] s_data;
    logic          m_ready;

    logic          s_ready_v [NI];
    logic          m_valid_v [NI];
    logic [SW-1:0] m_data_v  [NI];
    logic          m_last_v  [NI];
    logic          busy_v    [NI];
    logic [15:0]   fcnt_v    [NI];
    logic [N*SW-1:0] fdi_v   [NI];
    logic [N*SW-1:0] fdo_v   [NI];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    // Stub FFT: every element +0x0100.
    function automatic logic [N*SW-1:0] fft_stub(input logic [N*SW-1:0] x);
        logic [N*SW-1:0] r;
        for (int i = 0; i < N; i++) r[i*SW +: SW] = x[i*SW +: SW] + 16'h0100;
        return r;
    endfunction

    // Position k of the output stream reads result element ord(k).
    function automatic int ord(input int k);
`ifdef FFT_CTRL_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < $clog2(N); b++) if (k[b]) r = r | (1 << ($clog2(N) - 1 - b));
        return r;
`else
        return k;
`endif
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

        fft_frame_ctrl #(
            .N(N), .SAMPLE_WIDTH(SW), .FFT_LATENCY(LAT), .CNT_WIDTH(16)
        ) dut (
            .clk(clk),
            .rst(rst),
            .flush(flush),
            .s_valid(s_valid),
            .s_ready(s_ready_v[g]),
            .s_data(s_data),
            .fft_data_in(fdi_v[g]),
            .fft_data_out(fdo_v[g]),
            .m_valid(m_valid_v[g]),
            .m_ready(m_ready),
            .m_data(m_data_v[g]),
            .m_last(m_last_v[g]),
            .busy(busy_v[g]),
            .frame_count(fcnt_v[g])
        );

        if (LAT == 0) begin : g_comb
            assign fdo_v[g] = fft_stub(fdi_v[g]);
        end else begin : g_pipe
            logic [N*SW-1:0] pipe [LAT];
            always @(posedge clk) begin
                pipe[0] <= fft_stub(fdi_v[g]);
                for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
            end
            assign fdo_v[g] = pipe[LAT-1];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // ---------------- reference model (transaction level) ----------------
    // Per instance: samples of the partial frame, the frame in flight, the
    // cycle its last sample was accepted, and how many results were consumed.
    bit            sb_on = 1'b0;
    int            cyc   = 0;
    bit            have    [NI];
    int            part    [NI];
    logic [SW-1:0] img     [NI][N];
    logic [SW-1:0] frm     [NI][N];
    int            done_at [NI];
    int            pos     [NI];
    logic [15:0]   cnt     [NI];

    always @(negedge clk) begin : sb
        bit              emv;
        logic [SW-1:0]   emd;
        logic [N*SW-1:0] efdi;
        string           tag;
        for (int g = 0; g < NI; g++) begin
            // Results appear FFT_LATENCY+2 cycles after the last sample is seen.
            emv = have[g] && (cyc >= done_at[g] + lat_of(g) + 2);
            emd = emv ? 16'(frm[g][ord(pos[g])] + 16'h0100) : 16'h0000;
            for (int i = 0; i < N; i++) efdi[i*SW +: SW] = img[g][i];
            if (sb_on) begin
                tag = $sformatf("lat%0d cyc%0d", lat_of(g), cyc);
                check({tag, " s_ready"}, 64'(s_ready_v[g]), 64'(!have[g]));
                check({tag, " m_valid"}, 64'(m_valid_v[g]), 64'(emv));
                check({tag, " m_data"}, 64'(m_data_v[g]), 64'(emd));
                check({tag, " m_last"}, 64'(m_last_v[g]), 64'(emv && pos[g] == N - 1));
                check({tag, " busy"}, 64'(busy_v[g]), 64'(have[g] || part[g] != 0));
                check({tag, " frame_count"}, 64'(fcnt_v[g]), 64'(cnt[g]));
                check({tag, " fft_data_in"}, 64'(fdi_v[g]), 64'(efdi));
            end
            if (rst) begin
                have[g] = 1'b0;
                part[g] = 0;
                pos[g]  = 0;
                cnt[g]  = '0;
                for (int i = 0; i < N; i++) img[g][i] = '0;
            end else if (!have[g]) begin
                if (flush) begin
                    part[g] = 0;
                end else if (s_valid) begin
                    img[g][part[g]] = s_data;
                    part[g]++;
                    if (part[g] == N) begin
                        for (int i = 0; i < N; i++) frm[g][i] = img[g][i];
                        have[g]    = 1'b1;
                        part[g]    = 0;
                        done_at[g] = cyc;
                        pos[g]     = 0;
                    end
                end
            end else if (emv && m_ready) begin
                pos[g]++;
                if (pos[g] == N) begin
                    have[g] = 1'b0;
                    cnt[g]  = cnt[g] + 16'd1;
                end
            end
        end
        cyc++;
    end

    // ---------------- directed vector table (checked on the latency-1 instance) ----
    typedef struct {
        bit          rst;
        bit          flush;
        bit          sv;
        logic [15:0] sd;
        bit          mr;
        bit          e_sr;
        bit          e_mv;
        logic [15:0] e_md;
        bit          e_ml;
        bit          e_busy;
        logic [15:0] e_cnt;
        bit          chk_fdi;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input bit r, input bit f, input bit sv, input int sd, input bit mr,
                       input bit esr, input bit emv, input int emd, input bit eml,
                       input bit eb, input int ecnt, input bit cf = 1'b0);
        vec_t v;
        v.rst = r; v.flush = f; v.sv = sv; v.sd = 16'(sd); v.mr = mr;
        v.e_sr = esr; v.e_mv = emv; v.e_md = 16'(emd); v.e_ml = eml;
        v.e_busy = eb; v.e_cnt = 16'(ecnt); v.chk_fdi = cf;
        tbl.push_back(v);
    endtask

    // Expected k-th output of a frame whose inputs were base, base+1, ...
    function automatic int eo(input int k, input int base);
        return 32'h0100 + base + ord(k);
    endfunction

    int  wlen [NI];
    bit  got  [NI];

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

        // Single frame 1..4 with m_ready=1.
        for (int k = 0; k < 4; k++) add(0, 0, 1, k + 1, 1, 1, 0, 0, 0, k != 0, 0);
        repeat (2) add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, 0, 1, eo(k, 1), k == 3, 1, 0);
        // Backpressure: 5 stalled DRAIN cycles.
        for (int k = 0; k < 4; k++) add(0, 0, 1, k + 1, 0, 1, 0, 0, 0, k != 0, 1);
        repeat (2) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (5) add(0, 0, 0, 0, 0, 0, 1, eo(0, 1), 0, 1, 1);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, 0, 1, eo(k, 1), k == 3, 1, 1);
        // Flush drops 9 together with 7, 8; frame is 10..13.
        add(0, 0, 1, 7, 1, 1, 0, 0, 0, 0, 2);
        add(0, 0, 1, 8, 1, 1, 0, 0, 0, 1, 2);
        add(0, 1, 1, 9, 1, 1, 0, 0, 0, 1, 2);
        for (int k = 0; k < 4; k++) add(0, 0, 1, 10 + k, 1, 1, 0, 0, 0, k != 0, 2);
        repeat (2) add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2);
        for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 1, 0, 1, eo(k, 10), k == 3, 1, 2);
        // Reset after two outputs.
        for (int k = 0; k < 4; k++) add(0, 0, 1, k + 1, 1, 1, 0, 0, 0, k != 0, 3);
        repeat (2) add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 3);
        for (int k = 0; k < 2; k++) add(0, 0, 0, 0, 1, 0, 1, eo(k, 1), 0, 1, 3);
        add(1, 0, 0, 0, 0, 0, 1, eo(2, 1), 0, 1, 3);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        sb_on = 1'b1;

        foreach (tbl[r]) begin
            @(posedge clk);
            #1;
            rst = tbl[r].rst; flush = tbl[r].flush; s_valid = tbl[r].sv;
            s_data = tbl[r].sd; m_ready = tbl[r].mr;
            @(negedge clk);
            check($sformatf("vec%0d s_ready", r), 64'(s_ready_v[1]), 64'(tbl[r].e_sr));
            check($sformatf("vec%0d m_valid", r), 64'(m_valid_v[1]), 64'(tbl[r].e_mv));
            check($sformatf("vec%0d m_data", r), 64'(m_data_v[1]), 64'(tbl[r].e_md));
            check($sformatf("vec%0d m_last", r), 64'(m_last_v[1]), 64'(tbl[r].e_ml));
            check($sformatf("vec%0d busy", r), 64'(busy_v[1]), 64'(tbl[r].e_busy));
            check($sformatf("vec%0d frame_count", r), 64'(fcnt_v[1]), 64'(tbl[r].e_cnt));
            if (tbl[r].chk_fdi) check($sformatf("vec%0d fft_data_in", r), 64'(fdi_v[1]), 64'd0);
        end

        // WAIT length per latency build: FFT_LATENCY+1 cycles, then correct data.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            rst = 1'b0; flush = 1'b0; s_valid = 1'b1; s_data = 16'(32 + k); m_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int g = 0; g < NI; g++) begin
            wlen[g] = 0;
            got[g]  = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                if (!got[g]) begin
                    if (m_valid_v[g]) begin
                        got[g] = 1'b1;
                        check($sformatf("lat%0d first result", lat_of(g)), 64'(m_data_v[g]), 64'h0120);
                    end else if (!s_ready_v[g]) begin
                        wlen[g]++;
                    end
                end
            end
        end
        for (int g = 0; g < NI; g++) begin
            check($sformatf("lat%0d drain started", lat_of(g)), 64'(got[g]), 64'd1);
            check($sformatf("lat%0d wait cycles", lat_of(g)), 64'(wlen[g]), 64'(lat_of(g) + 1));
        end

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst     = ($urandom_range(0, 299) == 0);
            flush   = ($urandom_range(0, 19) == 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            m_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame sequencer for the parallel N-point FFT pipeline.
- Gathers a serial valid/ready sample stream into an N-wide frame and presents it on the FFT parallel input.
- Holds the frame stable for the FFT pipeline latency, then captures the parallel FFT output.
- Streams the captured result out serially with valid/ready and a last flag. Sits between the sample source and the result sink, wrapping one FFT instance.

Parameters:
- N, 4, points per frame; power of two, >= 2.
- SAMPLE_WIDTH, 16, bits per sample.
- FFT_LATENCY, 1, clock cycles from FFT input change to valid FFT output (NUM_STAGES-1 for the registered pipeline); 0 allowed.
- CNT_WIDTH, 16, width of frame_count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard partially collected input frame.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller accepts input sample.
- s_data  in  SAMPLE_WIDTH  input sample.
- fft_data_in  out  N*SAMPLE_WIDTH  frame to FFT; element i at bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- fft_data_out  in  N*SAMPLE_WIDTH  FFT result frame, same packing.
- m_valid  out  1  output sample valid.
- m_ready  in  1  sink accepts output sample.
- m_data  out  SAMPLE_WIDTH  output sample.
- m_last  out  1  marks element N-1 of a frame.
- busy  out  1  frame in flight.
- frame_count  out  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset is synchronous and active-high on clk.
  - On a rising edge with rst=1: state=COLLECT, wr_idx=0, rd_idx=0, wait_cnt=0.
  - The input and output buffers are cleared, so fft_data_in=0 and m_data=0.
  - s_ready=1, m_valid=0, m_last=0, busy=0, frame_count=0.
  - rst overrides all other inputs and aborts any state mid-frame.
- State machine has three states: COLLECT, WAIT, DRAIN.
- COLLECT:
  - s_ready=1. A handshake (s_valid & s_ready) writes s_data into in_buf[wr_idx] and increments wr_idx.
  - The handshake with wr_idx==N-1 writes the last element, clears wr_idx, sets wait_cnt=0 and moves to WAIT.
- fft_data_in is driven directly from in_buf, so it is registered. in_buf is written only in COLLECT, which keeps it stable through WAIT and DRAIN.
- WAIT:
  - s_ready=0.
  - If wait_cnt==FFT_LATENCY: capture fft_data_out into out_buf, set rd_idx=0 and move to DRAIN.
  - Otherwise increment wait_cnt.
  - WAIT lasts exactly FFT_LATENCY+1 cycles. The capture edge is FFT_LATENCY+1 edges after the edge that wrote the last input element.
- DRAIN:
  - s_ready=0, m_valid=1, m_data=out_buf[rd_idx], m_last=(rd_idx==N-1).
  - A handshake (m_valid & m_ready) increments rd_idx.
  - The handshake with m_last=1 increments frame_count and returns to COLLECT.
  - While m_ready=0, m_data and m_last hold stable. m_valid never drops without a handshake.
- No overlap: the next frame is not accepted until the previous frame has fully drained.
- busy = (state!=COLLECT) | (wr_idx!=0).
- flush:
  - In COLLECT it clears wr_idx on the next edge. If a handshake occurs in the same cycle, flush wins and the sample is dropped; s_ready still reads 1 that cycle.
  - in_buf is not cleared by flush.
  - flush is ignored in WAIT and DRAIN.
- No arithmetic on sample data; values pass through unchanged. Index counters are $clog2(N) bits. wait_cnt is wide enough for FFT_LATENCY (minimum 1 bit).
- m_data is 0 outside DRAIN.

Optional Feature:
- Macro FFT_CTRL_BITREV_EN.
- When defined, DRAIN reads out_buf[bitrev(rd_idx)], with bitrev reversing the $clog2(N) index bits. This puts the FFT output in natural frequency order (N=4 read order: 0,2,1,3).
- When undefined, read order is 0,1,...,N-1 (FFT native order).
- The macro affects nothing else.

Test Plan:
Bench stub for all scenarios: fft_data_out = fft_data_in delayed FFT_LATENCY cycles, with each element +16'h0100. N=4, FFT_LATENCY=1 unless stated.
- Single frame: s_data 1,2,3,4 with s_valid=1 and m_ready=1 -> s_ready=0 for 2 cycles, then m_data 0x0101,0x0102,0x0103,0x0104 on consecutive cycles with m_last on 0x0104, then frame_count=1 and s_ready=1.
- Backpressure: m_ready=0 for 5 cycles in DRAIN -> m_valid=1 and m_data=0x0101 held stable; drain resumes at 0x0102 when m_ready=1. s_ready stays 0 throughout.
- Flush: accept 7,8 then flush=1 concurrent with s_data=9 -> 9 dropped. Then 10,11,12,13 -> output 0x010A..0x010D.
- Reset mid-DRAIN: rst=1 after two outputs -> next edge m_valid=0, s_ready=1, frame_count=0, fft_data_in=0, busy=0.
- FFT_LATENCY=0 and FFT_LATENCY=3 builds -> WAIT lasts 1 and 4 cycles respectively, and captured data is correct.
- FFT_CTRL_BITREV_EN defined, input 1,2,3,4 -> output order 0x0101,0x0103,0x0102,0x0104.
